// File: rtl/mole_spawner_if.sv
// ----------------------------------------------------------------------------
// mole_spawner_if
// Mole/hit protocol bundle between the mole spawner (initiator) and the game
// logic responder.
//   hit_valid   responder -> spawner  one-cycle pulse: a switch was hit
//   hit_idx     responder -> spawner  index of the switch hit (5 bits)
//   ledr        spawner -> responder  one-hot lit mole, zero when none is up
//   mole_up     spawner -> responder  high while a mole is lit
//   active_idx  spawner -> responder  index of the current or most recent mole
//   hit_ack     spawner -> responder  one-cycle pulse: current mole was hit
//   miss        spawner -> responder  one-cycle pulse: timeout or wrong hit
// ----------------------------------------------------------------------------
interface mole_spawner_if #(
   parameter int unsigned NUM_MOLES = 18
);
   logic                 hit_valid;
   logic [4:0]           hit_idx;
   logic [NUM_MOLES-1:0] ledr;
   logic                 mole_up;
   logic [4:0]           active_idx;
   logic                 hit_ack;
   logic                 miss;

   modport master (
      input  hit_valid, hit_idx,
      output ledr, mole_up, active_idx, hit_ack, miss
   );

   modport slave (
      output hit_valid, hit_idx,
      input  ledr, mole_up, active_idx, hit_ack, miss
   );
endinterface

// File: rtl/mole_spawner.sv
// ----------------------------------------------------------------------------
// mole_spawner
// Raises one mole at a time on the LED bus, times its lifetime from the
// difficulty level and reports exactly one outcome (hit_ack or miss) per mole.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   enable      game running; low returns the block to IDLE
//   level       difficulty 0..3, lifetime = LIFE_MS_BASE >> level
//   bus         mole_spawner_if.master (hit_valid/hit_idx in; ledr, mole_up,
//               active_idx, hit_ack, miss out)
//   hit_count   saturating hit counter
//   miss_count  saturating miss counter
//
// Build option: define MOLE_STATS_EN to build the saturating hit/miss
// counters; without it both counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module mole_spawner #(
   parameter int unsigned NUM_MOLES    = 18,
   parameter int unsigned CLKS_PER_MS  = 50000,
   parameter int unsigned LIFE_MS_BASE = 1000,
   parameter int unsigned GAP_MS       = 250,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        level,
   mole_spawner_if.master    bus,
   output logic [7:0]        hit_count,
   output logic [7:0]        miss_count
);

   localparam int unsigned PRE_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int unsigned MS_MAX = (LIFE_MS_BASE > GAP_MS) ? LIFE_MS_BASE : GAP_MS;
   localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

   localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(CLKS_PER_MS - 1);
   localparam logic [MS_W-1:0]      LIFE_BASE = MS_W'(LIFE_MS_BASE);
   localparam logic [MS_W:0]        GAP_END   = (MS_W + 1)'(GAP_MS);
   localparam logic [NUM_MOLES-1:0] LED_ONE   = {{(NUM_MOLES - 1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GAP   = 2'd1,
      S_UP    = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_nxt;
   logic [PRE_W-1:0]     presc_r;
   logic [MS_W-1:0]      ms_r;
   logic [MS_W-1:0]      life_r;
   logic [15:0]          lfsr_r;
   logic [4:0]           active_r;
   logic [NUM_MOLES-1:0] ledr_r;
   logic                 mole_up_r;
   logic                 hit_ack_r;
   logic                 miss_r;

   logic                 tick_s;
   logic [MS_W:0]        ms_inc_s;
   logic                 lfsr_fb_s;
   logic [4:0]           cand_s;
   logic                 do_hit_s;
   logic                 do_miss_s;
   logic                 do_launch_s;

   // Fold a raw 5-bit LFSR sample into range and step off the previous index
   // so two consecutive moles never share a position.
   function automatic logic [4:0] pick_idx(input logic [4:0] raw, input logic [4:0] prev);
      logic [5:0] c;
      c = {1'b0, raw};
      for (int i = 0; i < 16; i++) begin
         if (c >= 6'(NUM_MOLES)) c = c - 6'(NUM_MOLES);
         else                    c = c;
      end
      if (c[4:0] == prev) begin
         if (c == 6'(NUM_MOLES - 1)) c = 6'd0;
         else                        c = c + 6'd1;
      end else begin
         c = c;
      end
      return c[4:0];
   endfunction

   assign tick_s    = (state_r != S_IDLE) && (presc_r == PRE_LAST);
   assign ms_inc_s  = {1'b0, ms_r} + {{MS_W{1'b0}}, 1'b1};
   assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
   assign cand_s    = pick_idx(lfsr_r[4:0], active_r);

   // Next-state and outcome decode; enable low overrides everything, and a
   // matching hit takes priority over lifetime expiry in the same cycle.
   always_comb begin
      state_nxt   = state_r;
      do_hit_s    = 1'b0;
      do_miss_s   = 1'b0;
      do_launch_s = 1'b0;
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: state_nxt = S_GAP;
            S_GAP: begin
               if (tick_s && (ms_inc_s >= GAP_END)) begin
                  state_nxt   = S_UP;
                  do_launch_s = 1'b1;
               end else begin
                  state_nxt = S_GAP;
               end
            end
            S_UP: begin
               if (bus.hit_valid) begin
                  if (bus.hit_idx == active_r) do_hit_s  = 1'b1;
                  else                         do_miss_s = 1'b1;
                  state_nxt = S_CLEAR;
               end else if (tick_s && (ms_inc_s >= {1'b0, life_r})) begin
                  do_miss_s = 1'b1;
                  state_nxt = S_CLEAR;
               end else begin
                  state_nxt = S_UP;
               end
            end
            S_CLEAR: state_nxt = S_GAP;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // State register, ms timebase, LFSR and registered protocol outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         presc_r   <= {PRE_W{1'b0}};
         ms_r      <= {MS_W{1'b0}};
         life_r    <= {MS_W{1'b0}};
         lfsr_r    <= LFSR_SEED;
         active_r  <= 5'd0;
         ledr_r    <= {NUM_MOLES{1'b0}};
         mole_up_r <= 1'b0;
         hit_ack_r <= 1'b0;
         miss_r    <= 1'b0;
      end else begin
         state_r <= state_nxt;
         lfsr_r  <= {lfsr_r[14:0], lfsr_fb_s};
         // Timebase restarts on every state entry and is parked in IDLE.
         if ((state_nxt != state_r) || (state_r == S_IDLE)) begin
            presc_r <= {PRE_W{1'b0}};
            ms_r    <= {MS_W{1'b0}};
         end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
            ms_r    <= ms_inc_s[MS_W-1:0];
         end else begin
            presc_r <= presc_r + {{(PRE_W - 1){1'b0}}, 1'b1};
            ms_r    <= ms_r;
         end
         // Index and lifetime are captured only at launch, so level changes
         // while a mole is up do not affect it.
         if (do_launch_s) begin
            active_r <= cand_s;
            life_r   <= LIFE_BASE >> level;
            ledr_r   <= LED_ONE << cand_s;
         end else if (state_nxt == S_UP) begin
            active_r <= active_r;
            life_r   <= life_r;
            ledr_r   <= ledr_r;
         end else begin
            active_r <= active_r;
            life_r   <= life_r;
            ledr_r   <= {NUM_MOLES{1'b0}};
         end
         mole_up_r <= (state_nxt == S_UP);
         hit_ack_r <= do_hit_s;
         miss_r    <= do_miss_s;
      end
   end

   assign bus.ledr       = ledr_r;
   assign bus.mole_up    = mole_up_r;
   assign bus.active_idx = active_r;
   assign bus.hit_ack    = hit_ack_r;
   assign bus.miss       = miss_r;

`ifdef MOLE_STATS_EN
   logic [7:0] hit_cnt_r;
   logic [7:0] miss_cnt_r;

   // Saturating outcome counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt_r  <= 8'd0;
         miss_cnt_r <= 8'd0;
      end else begin
         if (do_hit_s && (hit_cnt_r != 8'hFF)) hit_cnt_r <= hit_cnt_r + 8'd1;
         else                                  hit_cnt_r <= hit_cnt_r;
         if (do_miss_s && (miss_cnt_r != 8'hFF)) miss_cnt_r <= miss_cnt_r + 8'd1;
         else                                    miss_cnt_r <= miss_cnt_r;
      end
   end

   assign hit_count  = hit_cnt_r;
   assign miss_count = miss_cnt_r;
`else
   assign hit_count  = 8'd0;
   assign miss_count = 8'd0;
`endif

endmodule

// File: tb/tb_mole_spawner.sv
// ----------------------------------------------------------------------------
// tb_mole_spawner
// Randomized scoreboard bench for mole_spawner. The stimulus process reacts to
// each mole, picks an action (correct hit, wrong hit, timeout, hit on the
// expiry cycle, enable drop, reset) and pushes the outcome it expects, with
// the cycle it must appear on, into a queue. The monitor process pops and
// compares on every hit_ack/miss pulse and then checks the counters.
// ----------------------------------------------------------------------------
module tb_mole_spawner;
   localparam int NM      = 18;
   localparam int CPM     = 4;
   localparam int LIFE    = 8;
   localparam int GAPMS   = 2;
   localparam int GAP_CYC = GAPMS * CPM;

   localparam int M_HIT     = 0;
   localparam int M_WRONG   = 1;
   localparam int M_TIMEOUT = 2;
   localparam int M_EXPHIT  = 3;
   localparam int M_DROP    = 4;
   localparam int M_RESET   = 5;

`ifdef MOLE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      bit is_hit;
      int at;
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] level  = 2'd0;
   logic [7:0] hit_count;
   logic [7:0] miss_count;

   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   hits_m   = 0;
   int   misses_m = 0;
   bit   cnt_pending = 1'b0;
   int   cur_lvl  = 0;
   int   prev_idx = 0;
   int   exp_up   = -1;
   exp_t sbq[$];

   mole_spawner_if #(.NUM_MOLES(NM)) bus ();

   mole_spawner #(
      .NUM_MOLES   (NM),
      .CLKS_PER_MS (CPM),
      .LIFE_MS_BASE(LIFE),
      .GAP_MS      (GAPMS),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .level     (level),
      .bus       (bus),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sat(input int v);
      return STATS ? ((v > 255) ? 255 : v) : 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Wait (bounded) for the next mole; ledr must stay dark meanwhile.
   task automatic wait_up(output bit ok, output int up);
      int noisy;
      noisy = 0;
      ok    = 1'b0;
      up    = 0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (bus.mole_up) begin
            ok = 1'b1;
            up = cyc;
         end else if (bus.ledr != '0) begin
            noisy++;
         end
      end
      chk("ledr_dark_before_up", noisy, 0);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL mole_up_timeout: no mole within 100 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic expect_outcome(input bit is_hit, input int at);
      exp_t e;
      e.is_hit = is_hit;
      e.at     = at;
      sbq.push_back(e);
   endtask

   task automatic mole(input int mode, input int next_lvl, input bit fast);
      int             up;
      int             life_cyc;
      int             off;
      int             e_at;
      bit             ok;
      logic [4:0]     idx;
      logic [NM-1:0]  exp_ledr;
      wait_up(ok, up);
      if (!ok) return;
      if (exp_up >= 0) chk("mole_up_cycle", up, exp_up);
      idx = bus.active_idx;
      chk("idx_in_range", (int'(idx) < NM), 1);
      chk("idx_differs_from_prev", (int'(idx) != prev_idx), 1);
      exp_ledr = NM'(1) << idx;
      chk("ledr_onehot", bus.ledr, exp_ledr);
      prev_idx = int'(idx);
      life_cyc = (LIFE >> cur_lvl) * CPM;
      // New level only applies to the next launch.
      level   = 2'(next_lvl);
      cur_lvl = next_lvl;
      off  = fast ? 0 : $urandom_range(0, life_cyc - 1);
      e_at = -1;
      case (mode)
         M_HIT, M_WRONG, M_EXPHIT: begin
            if (mode == M_EXPHIT) off = life_cyc - 1;
            wait_until(up + off);
            bus.hit_valid = 1'b1;
            bus.hit_idx   = (mode == M_WRONG) ? idx + 5'($urandom_range(1, 31)) : idx;
            e_at = up + off + 1;
            expect_outcome(mode != M_WRONG, e_at);
            @(negedge clk);
            bus.hit_valid = 1'b0;
            chk("ledr_clear_after_hit", bus.ledr, 0);
            chk("mole_down_after_hit", bus.mole_up, 0);
         end
         M_TIMEOUT: begin
            e_at = up + life_cyc;
            expect_outcome(1'b0, e_at);
            wait_until(e_at - 1);
            chk("mole_still_up_last_cycle", bus.mole_up, 1);
            @(negedge clk);
            chk("mole_down_after_expiry", bus.mole_up, 0);
            chk("ledr_clear_after_expiry", bus.ledr, 0);
         end
         M_DROP: begin
            wait_until(up + off);
            enable = 1'b0;
            @(negedge clk);
            chk("ledr_clear_after_disable", bus.ledr, 0);
            chk("mole_down_after_disable", bus.mole_up, 0);
            repeat (2) @(negedge clk);
            enable = 1'b1;
            exp_up = cyc + 1 + GAP_CYC;
         end
         M_RESET: begin
            wait_until(up + off);
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst_ledr", bus.ledr, 0);
            chk("rst_mole_up", bus.mole_up, 0);
            chk("rst_active_idx", bus.active_idx, 0);
            chk("rst_hit_ack", bus.hit_ack, 0);
            chk("rst_miss", bus.miss, 0);
            chk("rst_hit_count", hit_count, 0);
            chk("rst_miss_count", miss_count, 0);
            sbq.delete();
            hits_m      = 0;
            misses_m    = 0;
            cnt_pending = 1'b0;
            prev_idx    = 0;
            rst_n       = 1'b1;
            exp_up      = cyc + 1 + GAP_CYC;
         end
         default: ;
      endcase
      if (e_at >= 0) begin
         exp_up = e_at + 1 + GAP_CYC;
         // Stray hit during CLEAR must be ignored.
         bus.hit_valid = 1'b1;
         bus.hit_idx   = idx;
         @(negedge clk);
         bus.hit_valid = 1'b0;
      end
   endtask

   // Monitor: pop the expected outcome on every pulse, then check counters.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (cnt_pending) begin
            chk("hit_count", hit_count, sat(hits_m));
            chk("miss_count", miss_count, sat(misses_m));
            cnt_pending = 1'b0;
         end
         if (bus.hit_ack || bus.miss) begin
            chk("pulse_exclusive", bus.hit_ack & bus.miss, 0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: hit_ack=%0b miss=%0b at cycle %0d, none expected",
                        bus.hit_ack, bus.miss, cyc);
            end else begin
               e = sbq.pop_front();
               chk("outcome_is_hit", bus.hit_ack, e.is_hit);
               chk("outcome_cycle", cyc, e.at);
               if (e.is_hit) hits_m++;
               else          misses_m++;
               cnt_pending = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded its time budget (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : stim
      int m;
      bus.hit_valid = 1'b0;
      bus.hit_idx   = 5'd0;
      repeat (3) @(negedge clk);
      chk("reset_ledr", bus.ledr, 0);
      chk("reset_mole_up", bus.mole_up, 0);
      chk("reset_active_idx", bus.active_idx, 0);
      chk("reset_hit_ack", bus.hit_ack, 0);
      chk("reset_miss", bus.miss, 0);
      chk("reset_hit_count", hit_count, 0);
      chk("reset_miss_count", miss_count, 0);
      rst_n   = 1'b1;
      enable  = 1'b1;
      level   = 2'd0;
      cur_lvl = 0;
      exp_up  = cyc + 1 + GAP_CYC;

      // Directed: lifetimes per level, wrong index, hit on expiry, disable, reset.
      mole(M_HIT, 2, 1'b0);
      mole(M_TIMEOUT, 0, 1'b0);
      mole(M_TIMEOUT, 3, 1'b0);
      mole(M_TIMEOUT, 1, 1'b0);
      mole(M_EXPHIT, 0, 1'b0);
      mole(M_WRONG, 2, 1'b0);
      mole(M_DROP, 1, 1'b0);
      mole(M_RESET, 0, 1'b0);

      // Randomized moles.
      for (int i = 0; i < 200; i++) begin
         m = $urandom_range(0, 9);
         if      (m <= 3) mole(M_HIT, $urandom_range(0, 3), 1'b0);
         else if (m <= 5) mole(M_WRONG, $urandom_range(0, 3), 1'b0);
         else if (m <= 7) mole(M_TIMEOUT, $urandom_range(0, 3), 1'b0);
         else if (m == 8) mole(M_EXPHIT, $urandom_range(0, 3), 1'b0);
         else             mole(M_DROP, $urandom_range(0, 3), 1'b0);
      end

      // Forced hits to drive the hit counter into saturation.
      for (int i = 0; i < 300; i++) mole(M_HIT, 3, 1'b1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      chk("hit_count_final", hit_count, sat(hits_m));
      chk("miss_count_final", miss_count, sat(misses_m));

      mole(M_RESET, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
Initiator side of the mole/hit protocol. Raises one mole at a time on the LED bus and consumes hit reports from the game logic responder. Times each mole's lifetime from the difficulty level. Emits exactly one outcome pulse per mole: hit_ack (feeds the score counter) or miss.

Parameters:
NUM_MOLES, 18, number of LED positions; legal range 2..32
CLKS_PER_MS, 50000, clk cycles per millisecond tick
LIFE_MS_BASE, 1000, mole lifetime in ms at level 0
GAP_MS, 250, idle time in ms between moles
LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
enable  in  1  game running; low returns the block to IDLE
level  in  2  difficulty level 0..3
hit_valid  in  1  one-cycle pulse from game logic: a switch was hit
hit_idx  in  5  index of the switch hit; qualified by hit_valid
ledr  out  NUM_MOLES  one-hot lit mole; all zero when no mole is up
mole_up  out  1  high while a mole is lit
active_idx  out  5  index of the current or most recent mole
hit_ack  out  1  one-cycle pulse: current mole was hit
miss  out  1  one-cycle pulse: mole timed out, or a wrong index was hit
hit_count  out  8  saturating hit counter (see Optional Feature)
miss_count  out  8  saturating miss counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; ledr=0; mole_up=0; active_idx=0; hit_ack=0; miss=0; counters=0; lfsr=LFSR_SEED; prescaler=0; ms counter=0.
- ms tick: the prescaler counts 0..CLKS_PER_MS-1 and tick=1 on the wrap cycle. The prescaler runs only outside IDLE and clears on every state entry.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including in IDLE.
- Index pick: raw=lfsr[4:0]. If raw>=NUM_MOLES, cand=raw-NUM_MOLES (repeat until in range). If cand==active_idx, cand=cand+1, wrapping to 0 at NUM_MOLES.
- States:
  - IDLE: outputs quiet. enable=1 -> GAP.
  - GAP: counts GAP_MS ticks, then -> UP. On the transition: latch cand into active_idx; latch life=LIFE_MS_BASE>>level. Level is sampled only here.
  - UP: ledr=1<<active_idx; mole_up=1; counts life ticks.
  - CLEAR: one cycle; ledr=0; -> GAP.
- Outcomes in UP:
  - hit_valid && hit_idx==active_idx -> hit_ack=1 next cycle, -> CLEAR.
  - hit_valid with any other index -> miss=1 next cycle, -> CLEAR.
  - Lifetime expires -> miss=1, -> CLEAR.
  - Hit and expiry in the same cycle -> the hit wins.
  - hit_valid outside UP is ignored.
- Exactly one outcome pulse per UP visit.
- Latency: from the hit_valid cycle, hit_ack and ledr=0 are both visible 1 cycle later.
- enable=0 in any state -> IDLE next cycle; ledr cleared; no outcome pulse; counters hold.
- rst_n=0 mid-mole: full reset as above, no pulse.
- Widths: the life counter is wide enough for LIFE_MS_BASE. The shift by level is logical, so the minimum life is LIFE_MS_BASE>>3.

Optional Feature:
MOLE_STATS_EN.
- Defined: hit_count increments on each hit_ack and miss_count on each miss; both saturate at 255 and clear only on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Sim params CLKS_PER_MS=4, LIFE_MS_BASE=8, GAP_MS=2. Reset then enable=1, level=0 -> ledr=0 for 8 cycles; mole_up rises on cycle 9; exactly one ledr bit set; index < 18.
- With a mole up, pulse hit_valid with hit_idx=active_idx -> hit_ack=1 for exactly 1 cycle, ledr=0 the next cycle; with MOLE_STATS_EN, hit_count=1.
- No hit, level=2 -> mole stays up exactly 2 ms (8 cycles), then a single miss pulse; level=0 gives 32 cycles.
- hit_valid with a wrong index -> miss pulse, no hit_ack; the same cycle as lifetime expiry with the correct index -> hit_ack only.
- Run 200 moles -> no two consecutive equal active_idx, all indices < NUM_MOLES; drop enable mid-UP -> ledr=0 next cycle, no pulse, state IDLE.
- 300 forced hits with MOLE_STATS_EN -> hit_count saturates at 255; assert rst_n=0 mid-mole -> all outputs 0 the next cycle.
